traffic_light_conflict_monitor: RTL
===================================

Name: traffic_light_conflict_monitor

Overview:
- Safety stage directly downstream of two_way_traffic_light_controller.
- Samples the controller's six lamp signals (A_/B_ green/yellow/red) every clock and drives the physical lamp outputs.
- Checks lamp encoding, cross-direction conflict, per-direction sequence and minimum dwell times.
- On the first violation it latches a fault code and forces both directions to flashing red until reset.

Parameters:
- MIN_GREEN, 5, minimum consecutive cycles a direction must show green.
- MIN_YELLOW, 3, minimum consecutive cycles a direction must show yellow.
- FLASH_HALF, 4, cycles red is on, and then off, per flash half-period in fault mode.
- CNT_W, 8, width of dwell and flash counters; dwell saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- A_green, A_yellow, A_red  in  1 each  direction A lamp requests from the controller.
- B_green, B_yellow, B_red  in  1 each  direction B lamp requests from the controller.
- A_green_o, A_yellow_o, A_red_o  out  1 each  direction A lamp drives.
- B_green_o, B_yellow_o, B_red_o  out  1 each  direction B lamp drives.
- fault  out  1  sticky fault flag.
- fault_code  out  3  first fault cause; 0 = none.

Behaviour:
- Reset (async, active-high):
  - all green/yellow outputs 0; A_red_o = B_red_o = 1;
  - fault = 0, fault_code = 0;
  - both direction trackers set to RED, dwell = 0, flash counter = 0.
- Sampling: inputs sampled at every rising clk edge.
- Normal mode: outputs are registered copies of inputs, latency 1 cycle.
- Per-direction tracker (A and B independent):
  - holds prev lamp (RED/GREEN/YELLOW) and a dwell counter.
  - Same lamp as prev: dwell increments, saturating at max.
  - Different lamp: check the transition and the previous dwell, then load the new lamp and set dwell = 1.
  - Legal transitions only: RED->GREEN, GREEN->YELLOW, YELLOW->RED. RED has no minimum dwell.
- Fault codes, evaluated on the sampled inputs at each edge:
  - 1 ILLEGAL_LAMP: a direction's three inputs are not exactly one-hot (zero lit or more than one lit).
  - 2 CONFLICT: both directions non-red (green or yellow) in the same sample.
  - 3 BAD_SEQUENCE: a transition not in the legal list, e.g. GREEN->RED, RED->YELLOW, YELLOW->GREEN.
  - 4 SHORT_YELLOW: leaving YELLOW with dwell < MIN_YELLOW.
  - 5 SHORT_GREEN: leaving GREEN with dwell < MIN_GREEN.
- Trackers are not updated on a sample that raises code 1.
- Simultaneous faults in one sample: lowest code number wins. A and B raising the same code yield that code once.
- Latching:
  - fault and fault_code are registered at the edge where the violation is sampled.
  - Once fault = 1, fault_code is frozen and later violations are ignored.
  - Only reset clears the fault.
- Fault mode, entered at the same edge as fault assertion:
  - all green/yellow outputs 0.
  - A_red_o = B_red_o = flash phase: 1 for FLASH_HALF cycles, then 0 for FLASH_HALF cycles, repeating.
  - Phase starts at 1 on the fault edge; the flash counter wraps cleanly.
- Reset mid-operation (including in fault mode): immediate return to reset values. The first post-reset sample is checked against the RED/RED trackers.
- Dwell saturation: a saturated green or yellow dwell still satisfies its minimum; no wrap to 0.

Test Plan:
- Legal cycle: reset 10 ns; drive A green 5 / yellow 3 / red, B red, then mirrored -> outputs track inputs with 1-cycle delay; fault stays 0, fault_code 0 throughout.
- Conflict: A_green=1 and B_green=1 in one sample -> next edge fault=1, fault_code=2, all greens 0. Both reds flash 1,1,1,1,0,0,0,0 cycles.
- Short yellow: A green 5 cycles, yellow 2 cycles, then red -> fault_code=4 at the red sample edge; flashing red starts that edge.
- Bad sequence plus lamp error: A green->red directly -> code 3. Separately, A_green=A_red=1 with B conflicting in the same sample -> code 1 wins over 2.
- Sticky and reset: after code 5, inject a conflict -> fault_code remains 5. Assert reset mid-flash -> outputs immediately reds 1, others 0, fault 0. A legal sequence afterward raises no fault.
- Saturation: CNT_W=3, A green 20 cycles, then yellow 3, then red -> no fault; dwell held at 7 without wrapping.

Source files
------------

// File: rtl/traffic_light_conflict_monitor.sv
// traffic_light_conflict_monitor
//
// Safety stage placed after a two-way traffic light controller. Every clock
// it samples the six lamp requests, forwards them to the physical lamps one
// cycle later and checks them for:
//   1 ILLEGAL_LAMP  - a direction is not exactly one-hot
//   2 CONFLICT      - both directions green/yellow at once
//   3 BAD_SEQUENCE  - transition other than RED->GREEN->YELLOW->RED
//   4 SHORT_YELLOW  - yellow left before MIN_YELLOW cycles
//   5 SHORT_GREEN   - green left before MIN_GREEN cycles
// The first violation latches fault/fault_code. From then until reset all
// green/yellow lamps are dark and both reds flash with a half-period of
// FLASH_HALF cycles.
//
// Ports:
//   clk, reset                        clock (rising edge), async active-high reset
//   A_green/A_yellow/A_red            direction A lamp requests
//   B_green/B_yellow/B_red            direction B lamp requests
//   A_green_o/A_yellow_o/A_red_o      direction A lamp drives
//   B_green_o/B_yellow_o/B_red_o      direction B lamp drives
//   fault                             sticky fault flag
//   fault_code                        first fault cause, 0 = none
module traffic_light_conflict_monitor #(
    parameter int MIN_GREEN  = 5,
    parameter int MIN_YELLOW = 3,
    parameter int FLASH_HALF = 4,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       A_green,
    input  logic       A_yellow,
    input  logic       A_red,
    input  logic       B_green,
    input  logic       B_yellow,
    input  logic       B_red,
    output logic       A_green_o,
    output logic       A_yellow_o,
    output logic       A_red_o,
    output logic       B_green_o,
    output logic       B_yellow_o,
    output logic       B_red_o,
    output logic       fault,
    output logic [2:0] fault_code
);

    typedef enum logic [1:0] {
        LAMP_RED    = 2'd0,
        LAMP_GREEN  = 2'd1,
        LAMP_YELLOW = 2'd2
    } lamp_t;

    localparam logic [CNT_W-1:0] DWELL_MAX  = '1;
    localparam logic [CNT_W-1:0] MIN_G_C    = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y_C    = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] FLASH_H_C  = CNT_W'(FLASH_HALF);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(2 * FLASH_HALF - 1);

    // Only meaningful when the three bits are one-hot.
    function automatic lamp_t decode_lamp(input logic g, input logic y);
        if (g)      return LAMP_GREEN;
        else if (y) return LAMP_YELLOW;
        else        return LAMP_RED;
    endfunction

    // Per-direction fault code (0, 1, 3, 4 or 5) for one sample.
    function automatic logic [2:0] dir_code(input logic g, input logic y,
                                            input logic r, input lamp_t prev,
                                            input logic [CNT_W-1:0] dwell);
        lamp_t cur;
        logic  legal;
        logic [2:0] code;
        code  = 3'd0;
        cur   = LAMP_RED;
        legal = 1'b0;
        if (!$onehot({g, y, r})) begin
            code = 3'd1;
        end else begin
            cur = decode_lamp(g, y);
            if (cur != prev) begin
                legal = (prev == LAMP_RED    && cur == LAMP_GREEN)  ||
                        (prev == LAMP_GREEN  && cur == LAMP_YELLOW) ||
                        (prev == LAMP_YELLOW && cur == LAMP_RED);
                if (!legal)                                     code = 3'd3;
                else if (prev == LAMP_YELLOW && dwell < MIN_Y_C) code = 3'd4;
                else if (prev == LAMP_GREEN  && dwell < MIN_G_C) code = 3'd5;
            end
        end
        return code;
    endfunction

    lamp_t            a_prev, a_prev_next, b_prev, b_prev_next;
    logic [CNT_W-1:0] a_dwell, a_dwell_next, b_dwell, b_dwell_next;
    logic [CNT_W-1:0] flash_cnt, flash_next;
    logic [2:0]       a_code, b_code, sample_code;
    logic             conflict;
    lamp_t            a_cur, b_cur;

    // Fault evaluation and tracker next state.
    always_comb begin
        a_code   = dir_code(A_green, A_yellow, A_red, a_prev, a_dwell);
        b_code   = dir_code(B_green, B_yellow, B_red, b_prev, b_dwell);
        conflict = (A_green | A_yellow) & (B_green | B_yellow);

        // Lowest code wins.
        sample_code = 3'd0;
        if (a_code == 3'd1 || b_code == 3'd1)      sample_code = 3'd1;
        else if (conflict)                         sample_code = 3'd2;
        else if (a_code == 3'd3 || b_code == 3'd3) sample_code = 3'd3;
        else if (a_code == 3'd4 || b_code == 3'd4) sample_code = 3'd4;
        else if (a_code == 3'd5 || b_code == 3'd5) sample_code = 3'd5;

        a_cur        = decode_lamp(A_green, A_yellow);
        b_cur        = decode_lamp(B_green, B_yellow);
        a_prev_next  = a_prev;
        a_dwell_next = a_dwell;
        b_prev_next  = b_prev;
        b_dwell_next = b_dwell;
        // A malformed lamp sample carries no usable lamp, so trackers hold.
        if (sample_code != 3'd1) begin
            if (a_cur == a_prev) begin
                if (a_dwell != DWELL_MAX) a_dwell_next = a_dwell + 1'b1;
            end else begin
                a_prev_next  = a_cur;
                a_dwell_next = CNT_W'(1);
            end
            if (b_cur == b_prev) begin
                if (b_dwell != DWELL_MAX) b_dwell_next = b_dwell + 1'b1;
            end else begin
                b_prev_next  = b_cur;
                b_dwell_next = CNT_W'(1);
            end
        end

        flash_next = (flash_cnt == FLASH_LAST) ? '0 : flash_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_prev     <= LAMP_RED;
            b_prev     <= LAMP_RED;
            a_dwell    <= '0;
            b_dwell    <= '0;
            flash_cnt  <= '0;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            A_green_o  <= 1'b0;
            A_yellow_o <= 1'b0;
            A_red_o    <= 1'b1;
            B_green_o  <= 1'b0;
            B_yellow_o <= 1'b0;
            B_red_o    <= 1'b1;
        end else begin
            a_prev  <= a_prev_next;
            b_prev  <= b_prev_next;
            a_dwell <= a_dwell_next;
            b_dwell <= b_dwell_next;
            if (!fault && sample_code != 3'd0) begin
                // Fault edge: flash phase begins lit with counter at 0.
                fault      <= 1'b1;
                fault_code <= sample_code;
                flash_cnt  <= '0;
                A_green_o  <= 1'b0;
                A_yellow_o <= 1'b0;
                A_red_o    <= 1'b1;
                B_green_o  <= 1'b0;
                B_yellow_o <= 1'b0;
                B_red_o    <= 1'b1;
            end else if (fault) begin
                flash_cnt  <= flash_next;
                A_green_o  <= 1'b0;
                A_yellow_o <= 1'b0;
                A_red_o    <= (flash_next < FLASH_H_C);
                B_green_o  <= 1'b0;
                B_yellow_o <= 1'b0;
                B_red_o    <= (flash_next < FLASH_H_C);
            end else begin
                A_green_o  <= A_green;
                A_yellow_o <= A_yellow;
                A_red_o    <= A_red;
                B_green_o  <= B_green;
                B_yellow_o <= B_yellow;
                B_red_o    <= B_red;
            end
        end
    end

endmodule
